multi_port_free_list: RTL and testbench

Parametrised multi-port physical-register free list for the renamer, successor to the single-port free list. Supplies up to POP_PORTS free tags per cycle to rename, accepts up to PUSH_PORTS retired tags per cycle from commit, and restores a variable number of speculatively allocated tags in one cycle on flush. Self-initialises after reset with a configurable tag range, so the renamer needs no external fill logic.

---
 rtl/multi_port_free_list_pkg.sv | 30 +++
 rtl/multi_port_free_list_pointers.sv | 92 +++++++++
 rtl/multi_port_free_list.sv | 91 +++++++++
 tb/tb_multi_port_free_list.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_port_free_list_pkg.sv
// Shared free-list types, renamer defaults, state encoding and port-count helpers.
package multi_port_free_list_pkg;

  localparam int unsigned FL_DATA_WIDTH = 6;
  localparam int unsigned FL_DEPTH      = 32;
  localparam int unsigned FL_POP_PORTS  = 2;
  localparam int unsigned FL_PUSH_PORTS = 2;
  localparam int unsigned FL_INIT_BASE  = 32;

  typedef logic [FL_DATA_WIDTH-1:0] fl_tag_t;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Number of set bits in a (zero-extended) port-valid vector.
  function automatic int unsigned port_count(input logic [3:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) cnt++;
    end
    return cnt;
  endfunction

  // True when the valid bits form a contiguous run starting at bit 0.
  function automatic logic is_therm(input logic [3:0] v);
    return (v & (v + 4'd1)) == 4'd0;
  endfunction

endpackage

// File: rtl/multi_port_free_list_pointers.sv
// Read/write index, free-count arithmetic and the INIT/RUN sequencing of the free list.
module multi_port_free_list_pointers
  import multi_port_free_list_pkg::*;
#(
  parameter int unsigned DEPTH      = FL_DEPTH,
  parameter int unsigned POP_PORTS  = FL_POP_PORTS,
  parameter int unsigned PUSH_PORTS = FL_PUSH_PORTS,
  localparam int unsigned IW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [POP_PORTS-1:0]  pop,
  input  logic [PUSH_PORTS-1:0] push,
  input  logic                  rollback,
  input  logic [CW-1:0]         rollback_count,
  output logic                  init_active_c,
  output logic [IW-1:0]         init_index,
  output logic [IW-1:0]         read_index,
  output logic [IW-1:0]         write_index,
  output logic [CW-1:0]         free_count,
  output logic                  init_done,
  output logic                  pop_ready
);

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] init_index_q, init_index_d;
  logic [IW-1:0] read_index_q, read_index_d;
  logic [IW-1:0] write_index_q, write_index_d;
  logic [CW-1:0] free_count_q, free_count_d;
  logic          init_done_q, init_done_d;
  logic          pop_ready_q, pop_ready_d;
  logic [CW-1:0] npop, npush, nrb;

  always_comb begin
    state_d       = state_q;
    init_index_d  = init_index_q;
    read_index_d  = read_index_q;
    write_index_d = write_index_q;
    free_count_d  = free_count_q;
    npop          = CW'(port_count(4'(pop)));
    npush         = CW'(port_count(4'(push)));
    nrb           = rollback ? rollback_count : '0;

    if (state_q == ST_INIT) begin
      init_index_d = init_index_q + IW'(1);
      if (init_index_q == IW'(DEPTH - 1)) begin
        state_d       = ST_RUN;
        free_count_d  = CW'(DEPTH);
        read_index_d  = '0;
        write_index_d = '0;
      end
    end else begin
      // Rollback rewinds the read pointer over slots that still hold the popped tags.
      read_index_d  = read_index_q + IW'(npop) - IW'(nrb);
      write_index_d = write_index_q + IW'(npush);
      free_count_d  = free_count_q - npop + npush + nrb;
    end

    init_done_d = (state_d == ST_RUN);
    pop_ready_d = (state_d == ST_RUN) && (free_count_d >= CW'(POP_PORTS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      init_index_q  <= '0;
      read_index_q  <= '0;
      write_index_q <= '0;
      free_count_q  <= '0;
      init_done_q   <= 1'b0;
      pop_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_index_q  <= init_index_d;
      read_index_q  <= read_index_d;
      write_index_q <= write_index_d;
      free_count_q  <= free_count_d;
      init_done_q   <= init_done_d;
      pop_ready_q   <= pop_ready_d;
    end
  end

  assign init_active_c = (state_q == ST_INIT);
  assign init_index    = init_index_q;
  assign read_index    = read_index_q;
  assign write_index   = write_index_q;
  assign free_count    = free_count_q;
  assign init_done     = init_done_q;
  assign pop_ready     = pop_ready_q;

endmodule

// File: rtl/multi_port_free_list.sv
// Multi-port physical-register free list: tag storage plus pointer block, self-filling after reset.
module multi_port_free_list
  import multi_port_free_list_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FL_DATA_WIDTH,
  parameter int unsigned DEPTH      = FL_DEPTH,
  parameter int unsigned POP_PORTS  = FL_POP_PORTS,
  parameter int unsigned PUSH_PORTS = FL_PUSH_PORTS,
  parameter int unsigned INIT_BASE  = FL_INIT_BASE,
  localparam int unsigned IW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [POP_PORTS-1:0]             pop,
  output logic [POP_PORTS*DATA_WIDTH-1:0]  data_out,
  output logic                             pop_ready,
  output logic [CW-1:0]                    free_count,
  input  logic [PUSH_PORTS-1:0]            push,
  input  logic [PUSH_PORTS*DATA_WIDTH-1:0] push_data,
  input  logic                             rollback,
  input  logic [CW-1:0]                    rollback_count,
  output logic                             init_done
);

  logic                  init_active_c;
  logic [IW-1:0]         init_index;
  logic [IW-1:0]         read_index;
  logic [IW-1:0]         write_index;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]         nrb_c;

  multi_port_free_list_pointers #(
    .DEPTH      (DEPTH),
    .POP_PORTS  (POP_PORTS),
    .PUSH_PORTS (PUSH_PORTS)
  ) u_pointers (
    .clk            (clk),
    .rst            (rst),
    .pop            (pop),
    .push           (push),
    .rollback       (rollback),
    .rollback_count (rollback_count),
    .init_active_c  (init_active_c),
    .init_index     (init_index),
    .read_index     (read_index),
    .write_index    (write_index),
    .free_count     (free_count),
    .init_done      (init_done),
    .pop_ready      (pop_ready)
  );

  // Fill one slot per cycle during INIT, otherwise accept released tags at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (init_active_c) begin
      mem_d[init_index] = DATA_WIDTH'(INIT_BASE) + DATA_WIDTH'(init_index);
    end else begin
      for (int j = 0; j < PUSH_PORTS; j++) begin
        if (push[j]) begin
          mem_d[write_index + IW'(j)] = push_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < POP_PORTS; i++) begin
      data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[read_index + IW'(i)];
    end
  end

  assign nrb_c = rollback ? rollback_count : '0;

  always @(posedge clk) begin
    if (!rst && !init_active_c) begin
      assert (!(rollback && (|pop)));
      assert (is_therm(4'(pop)));
      assert (is_therm(4'(push)));
      assert (port_count(4'(pop)) <= 32'(free_count));
      assert (32'(free_count) + port_count(4'(push)) + 32'(nrb_c) <= DEPTH);
    end
  end

endmodule

// File: tb/tb_multi_port_free_list.sv
// Directed vector table, hand-written reset sequences and randomized traffic against a queue model.
module tb_multi_port_free_list;

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    pop;
  logic [7:0]    data_out;
  logic          pop_ready;
  logic [CW-1:0] free_count;
  logic [1:0]    push;
  logic [7:0]    push_data;
  logic          rollback;
  logic [CW-1:0] rollback_count;
  logic          init_done;
  logic [3:0]    d0, d1;

  int n_checks = 0;
  int n_fail   = 0;

  multi_port_free_list #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .POP_PORTS  (2),
    .PUSH_PORTS (2),
    .INIT_BASE  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pop            (pop),
    .data_out       (data_out),
    .pop_ready      (pop_ready),
    .free_count     (free_count),
    .push           (push),
    .push_data      (push_data),
    .rollback       (rollback),
    .rollback_count (rollback_count),
    .init_done      (init_done)
  );

  assign d0 = data_out[3:0];
  assign d1 = data_out[7:4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pop;
    logic [1:0] push;
    logic [3:0] pd0;
    logic [3:0] pd1;
    logic       rb;
    logic [3:0] rbc;
    int         exp_free;
    int         exp_d0;   // -1: not checked
    int         exp_d1;   // -1: not checked
  } vec_t;

  vec_t vecs[12];

  logic [3:0] fq[$];
  logic [3:0] hq[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle;
    pop = 2'b00; push = 2'b00; push_data = 8'h00; rollback = 1'b0; rollback_count = 4'd0;
  endtask

  // Reset, optionally re-reset part-way through the fill, then wait for fill completion.
  task automatic do_init(input int abort_at);
    int cycles;
    idle();
    rst = 1'b1;
    tick();
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_free_count", 32'(free_count), 0);
    chk("rst_pop_ready", 32'(pop_ready), 0);
    rst = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at) tick();
      rst = 1'b1;
      tick();
      chk("midinit_init_done", 32'(init_done), 0);
      chk("midinit_free_count", 32'(free_count), 0);
      rst = 1'b0;
    end
    cycles = 0;
    while (!init_done && cycles < 20) begin
      tick();
      cycles++;
    end
    chk("init_latency", 32'(cycles), 8);
    chk("init_free_count", 32'(free_count), 8);
    chk("init_pop_ready", 32'(pop_ready), 1);
    chk("init_d0", 32'(d0), 8);
    chk("init_d1", 32'(d1), 9);
  endtask

  function automatic logic [1:0] therm(input int n);
    return (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
  endfunction

  initial begin
    int npop, npush, nrb, lim, fr;
    logic [3:0] pd0, pd1;

    rst = 1'b1;
    idle();

    // Fresh reset and fill timing.
    do_init(0);

    // Directed table from a freshly filled list (tags 8..15).
    vecs[0]  = '{2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 6, 10, 11};
    vecs[1]  = '{2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 4, 12, 13};
    vecs[2]  = '{2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2, 14, 15};
    vecs[3]  = '{2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 0, -1, -1};
    vecs[4]  = '{2'b00, 2'b11, 4'd3, 4'd5, 1'b0, 4'd0, 2, 3, 5};
    vecs[5]  = '{2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1, 5, -1};
    vecs[6]  = '{2'b00, 2'b00, 4'd0, 4'd0, 1'b1, 4'd3, 4, 14, 15};
    vecs[7]  = '{2'b00, 2'b11, 4'd1, 4'd2, 1'b1, 4'd1, 7, 13, 14};
    vecs[8]  = '{2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 5, 15, 3};
    vecs[9]  = '{2'b11, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 3, 5, 1};
    vecs[10] = '{2'b11, 2'b01, 4'd7, 4'd0, 1'b0, 4'd0, 2, 2, 7};
    vecs[11] = '{2'b00, 2'b00, 4'd0, 4'd0, 1'b0, 4'd5, 2, 2, 7};

    for (int i = 0; i < 12; i++) begin
      pop            = vecs[i].pop;
      push           = vecs[i].push;
      push_data      = {vecs[i].pd1, vecs[i].pd0};
      rollback       = vecs[i].rb;
      rollback_count = vecs[i].rbc;
      tick();
      chk($sformatf("vec%0d_free_count", i), 32'(free_count), 32'(vecs[i].exp_free));
      chk($sformatf("vec%0d_pop_ready", i), 32'(pop_ready), (vecs[i].exp_free >= 2) ? 1 : 0);
      if (vecs[i].exp_d0 >= 0) chk($sformatf("vec%0d_d0", i), 32'(d0), 32'(vecs[i].exp_d0));
      if (vecs[i].exp_d1 >= 0) chk($sformatf("vec%0d_d1", i), 32'(d1), 32'(vecs[i].exp_d1));
    end
    idle();

    // Pop 8,9,10,11 then roll back the last three.
    do_init(0);
    pop = 2'b11; tick();
    pop = 2'b11; tick();
    pop = 2'b00; rollback = 1'b1; rollback_count = 4'd3; tick();
    idle();
    chk("rb_free_count", 32'(free_count), 7);
    chk("rb_d0", 32'(d0), 9);
    chk("rb_d1", 32'(d1), 10);
    chk("rb_pop_ready", 32'(pop_ready), 1);

    // Reset in the middle of the fill, then drain everything in order.
    do_init(4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_d0", k), 32'(d0), 32'(8 + 2*k));
      chk($sformatf("drain%0d_d1", k), 32'(d1), 32'(9 + 2*k));
      pop = 2'b11;
      tick();
    end
    idle();
    chk("drain_free_count", 32'(free_count), 0);
    chk("drain_pop_ready", 32'(pop_ready), 0);

    // Randomized legal traffic against a free-queue / popped-history model.
    fq.delete();
    hq.delete();
    for (int t = 8; t < 16; t++) hq.push_back(4'(t));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fr = fq.size();
      pd0 = 4'($urandom_range(0, 15));
      pd1 = 4'($urandom_range(0, 15));
      rollback = 1'b0;
      rollback_count = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 9) < 2) begin
        npop  = 0;
        npush = int'($urandom_range(0, ((8 - fr) < 2) ? (8 - fr) : 2));
        lim   = 8 - fr - npush;
        if (hq.size() < lim) lim = hq.size();
        nrb   = int'($urandom_range(0, lim));
        rollback = 1'b1;
        rollback_count = 4'(nrb);
      end else begin
        npop  = int'($urandom_range(0, (fr < 2) ? fr : 2));
        npush = int'($urandom_range(0, ((8 - fr) < 2) ? (8 - fr) : 2));
        nrb   = 0;
      end
      pop       = therm(npop);
      push      = therm(npush);
      push_data = {pd1, pd0};
      tick();

      for (int k = 0; k < npop; k++) hq.push_back(fq.pop_front());
      for (int k = 0; k < nrb; k++) fq.push_front(hq.pop_back());
      if (npush >= 1) fq.push_back(pd0);
      if (npush >= 2) fq.push_back(pd1);
      while (hq.size() > 8) void'(hq.pop_front());

      chk("rand_free_count", 32'(free_count), 32'(fq.size()));
      chk("rand_pop_ready", 32'(pop_ready), (fq.size() >= 2) ? 1 : 0);
      chk("rand_init_done", 32'(init_done), 1);
      if (fq.size() > 0) chk("rand_d0", 32'(d0), 32'(fq[0]));
      if (fq.size() > 1) chk("rand_d1", 32'(d1), 32'(fq[1]));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
